// File: rtl/branch_control_unit_if.sv
// Bundle of instruction/condition inputs and datapath control strobes
// exchanged between the branch control unit and the datapath.
interface branch_control_unit_if;
  logic [31:0] IR;
  logic        CON_Out;
  logic        PCout, MARin, Read, MDRin, IncPC, MDRout, IRin;
  logic        Gra, Rout, CON_In, Yin, Cout, ZLowin, ZHighin, ZLowout, PCin;
  logic [4:0]  OP;
  logic        Run;
  logic        Illegal;

  modport master (
    input  IR, CON_Out,
    output PCout, MARin, Read, MDRin, IncPC, MDRout, IRin,
    output Gra, Rout, CON_In, Yin, Cout, ZLowin, ZHighin, ZLowout, PCin,
    output OP, Run, Illegal
  );

  modport slave (
    output IR, CON_Out,
    input  PCout, MARin, Read, MDRin, IncPC, MDRout, IRin,
    input  Gra, Rout, CON_In, Yin, Cout, ZLowin, ZHighin, ZLowout, PCin,
    input  OP, Run, Illegal
  );
endinterface

// File: rtl/branch_control_unit.sv
// Fetch/branch/jr/halt sequencer: one FSM stepping T0..T6, with outputs decoded
// from the current state (IR only in T3, CON_Out only in T6).
module branch_control_unit (
  input logic                   Clock,
  input logic                   Clear,
  branch_control_unit_if.master bus
);

  localparam logic [4:0] OpBranch = 5'b10011;
  localparam logic [4:0] OpJr     = 5'b10100;
  localparam logic [4:0] OpHalt   = 5'b11011;
  localparam logic [4:0] AluAdd   = 5'b00100;

  typedef enum logic [3:0] {
    StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
  } state_e;

  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [4:0]  opcode;

  assign opcode = bus.IR[31:27];

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q   <= StReset;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StReset: state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    state_d = StT2;
      StT2:    state_d = StT3;
      StT3: begin
        if (opcode == OpBranch) begin
          state_d = StT4;
        end else if (opcode == OpJr) begin
          state_d = StT0;
        end else begin
          // Remember why we stopped so Illegal can be reported while halted.
          state_d   = StHalt;
          illegal_d = (opcode != OpHalt);
        end
      end
      StT4:    state_d = StT5;
      StT5:    state_d = StT6;
      StT6:    state_d = StT0;
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
  end

  always_comb begin
    bus.PCout   = 1'b0;
    bus.MARin   = 1'b0;
    bus.Read    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.IncPC   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Gra     = 1'b0;
    bus.Rout    = 1'b0;
    bus.CON_In  = 1'b0;
    bus.Yin     = 1'b0;
    bus.Cout    = 1'b0;
    bus.ZLowin  = 1'b0;
    bus.ZHighin = 1'b0;
    bus.ZLowout = 1'b0;
    bus.PCin    = 1'b0;
    bus.OP      = 5'b00000;
    bus.Run     = (state_q != StReset) && (state_q != StHalt);
    bus.Illegal = (state_q == StHalt) && illegal_q;
    unique case (state_q)
      StT0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
      end
      StT1: bus.IncPC = 1'b1;
      StT2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      StT3: begin
        if (opcode == OpBranch) begin
          bus.Gra    = 1'b1;
          bus.Rout   = 1'b1;
          bus.CON_In = 1'b1;
        end else if (opcode == OpJr) begin
          bus.Gra  = 1'b1;
          bus.Rout = 1'b1;
          bus.PCin = 1'b1;
        end
      end
      StT4: begin
        bus.PCout = 1'b1;
        bus.Yin   = 1'b1;
      end
      StT5: begin
        bus.Cout    = 1'b1;
        bus.ZLowin  = 1'b1;
        bus.ZHighin = 1'b1;
        bus.OP      = AluAdd;
      end
      StT6: begin
        bus.ZLowout = 1'b1;
        bus.PCin    = bus.CON_Out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_branch_control_unit.sv
// Randomized bench for branch_control_unit: per-instruction expected strobe
// traces are built from the opcode class and compared cycle by cycle.
module tb_branch_control_unit;

  localparam logic [4:0] OpBranch = 5'b10011;
  localparam logic [4:0] OpJr     = 5'b10100;
  localparam logic [4:0] OpHalt   = 5'b11011;

  // Observation vector bit positions.
  localparam int BPcout = 0, BMarin = 1, BRead = 2, BMdrin = 3, BIncpc = 4, BMdrout = 5;
  localparam int BIrin = 6, BGra = 7, BRout = 8, BConin = 9, BYin = 10, BCout = 11;
  localparam int BZlowin = 12, BZhighin = 13, BZlowout = 14, BPcin = 15, BRun = 21;
  localparam int BIllegal = 22;

  typedef logic [22:0] vec_t;

  logic Clock;
  logic Clear;
  int   n_checks;
  int   n_fail;

  branch_control_unit_if bus ();

  branch_control_unit dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  vec_t obs;
  assign obs = {bus.Illegal, bus.Run, bus.OP, bus.PCin, bus.ZLowout, bus.ZHighin, bus.ZLowin,
                bus.Cout, bus.Yin, bus.CON_In, bus.Rout, bus.Gra, bus.IRin, bus.MDRout,
                bus.IncPC, bus.MDRin, bus.Read, bus.MARin, bus.PCout};

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  // Expected outputs for step s (T0..T6) of an instruction with opcode opc.
  function automatic vec_t expect_step(input int s, input logic [4:0] opc, input logic con);
    vec_t v;
    v = '0;
    v[BRun] = 1'b1;
    case (s)
      0: begin v[BPcout] = 1; v[BMarin] = 1; v[BRead] = 1; v[BMdrin] = 1; end
      1: v[BIncpc] = 1;
      2: begin v[BMdrout] = 1; v[BIrin] = 1; end
      3: begin
        if (opc == OpBranch) begin v[BGra] = 1; v[BRout] = 1; v[BConin] = 1; end
        if (opc == OpJr)     begin v[BGra] = 1; v[BRout] = 1; v[BPcin] = 1; end
      end
      4: begin v[BPcout] = 1; v[BYin] = 1; end
      5: begin v[BCout] = 1; v[BZlowin] = 1; v[BZhighin] = 1; v[20:16] = 5'd4; end
      6: begin v[BZlowout] = 1; v[BPcin] = con; end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic vec_t expect_halt(input logic [4:0] opc);
    vec_t v;
    v = '0;
    v[BIllegal] = (opc != OpHalt);
    return v;
  endfunction

  // Assert Clear away from the clock edge, confirm outputs drop at once and stay
  // low across an edge, then release; the first edge after release lands in T0.
  task automatic do_reset();
    Clear = 1'b1;
    #1;
    check("clear_immediate", obs, '0);
    @(posedge Clock);
    #1;
    check("clear_hold", obs, '0);
    @(negedge Clock);
    Clear = 1'b0;
    @(posedge Clock);
  endtask

  task automatic check_drivers(input string tag);
    int nd;
    nd = $countones({bus.PCout, bus.MDRout, bus.Rout, bus.Cout, bus.ZLowout});
    check(tag, vec_t'(nd <= 1), vec_t'(1));
  endtask

  // Runs one instruction starting in T0. noisy scrambles IR outside T3 and
  // CON_Out every cycle; abort_at >= 0 pulses Clear during that step.
  task automatic run_instr(input logic [31:0] instr, input bit noisy, input logic con_fixed,
                           input int abort_at);
    logic [4:0] opc;
    int         len;
    opc = instr[31:27];
    len = (opc == OpBranch) ? 7 : 4;
    for (int s = 0; s < len; s++) begin
      @(negedge Clock);
      bus.IR      = (noisy && s != 3) ? $urandom : instr;
      bus.CON_Out = noisy ? 1'($urandom) : con_fixed;
      #1;
      if (s == abort_at) begin
        do_reset();
        return;
      end
      check($sformatf("op%02h_t%0d", opc, s), obs, expect_step(s, opc, bus.CON_Out));
      check_drivers($sformatf("drivers_t%0d", s));
      @(posedge Clock);
    end
    if (opc != OpBranch && opc != OpJr) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge Clock);
        bus.IR      = $urandom;
        bus.CON_Out = 1'($urandom);
        #1;
        check($sformatf("halt_op%02h_%0d", opc, k), obs, expect_halt(opc));
        @(posedge Clock);
      end
      @(negedge Clock);
      #2;
      do_reset();
    end
  endtask

  initial begin
    logic [31:0] instr;
    logic [4:0]  opc;
    n_checks    = 0;
    n_fail      = 0;
    Clear       = 1'b1;
    bus.IR      = '0;
    bus.CON_Out = 1'b0;
    #1;
    check("reset_state", obs, '0);
    @(negedge Clock);
    Clear = 1'b0;
    @(posedge Clock);

    run_instr(32'h9B180019, 1'b0, 1'b1, -1);   // brmi taken
    run_instr(32'h9B000019, 1'b0, 1'b0, -1);   // brzr not taken
    run_instr({OpJr, 27'h0123456}, 1'b0, 1'b1, -1);
    run_instr(32'h9B180019, 1'b1, 1'b0, -1);   // isolation with noise
    run_instr(32'h9B180019, 1'b0, 1'b1, 4);    // Clear mid-T4
    run_instr(32'h9B180019, 1'b0, 1'b1, -1);
    run_instr({OpHalt, 27'h0}, 1'b0, 1'b0, -1);
    run_instr({5'b11111, 27'h0}, 1'b0, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       opc = OpBranch;
        1:       opc = OpJr;
        2:       opc = OpHalt;
        default: begin
          opc = 5'($urandom);
          while (opc == OpBranch || opc == OpJr || opc == OpHalt) opc = 5'($urandom);
        end
      endcase
      instr = {opc, 27'($urandom)};
      run_instr(instr, 1'b1, 1'b0,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
